lc2k_ctrl_fsm: RTL and testbench
================================

LC2K_CTRL_FSM -- requirements
Module: lc2k_ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 Parameter TO_CYC, default 15: maximum memory wait cycles before fault; legal range 1..255.
REQ-003 Port clk, input, 1: sole clock; the block is clocked on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: begin execution; sampled only in IDLE and HALT.
REQ-006 Port opcode, input, 3: instruction-register opcode, valid in DECODE.
REQ-007 Port alu_eq, input, 1: branch comparison result, valid in EXEC.
REQ-008 Port mem_ready, input, 1: memory handshake acknowledge.
REQ-009 Control output ports, each 1 bit: pc_we, ir_we, mem_req, mem_we, reg_we, wr_reg_sel (1 = dest, 0 = regB), alu_b_sel (1 = regB, 0 = offset).
REQ-010 Control output ports, each 2 bits: wr_data_sel (0 = mem, 1 = ALU, 2 = pc+1), alu_op (0 = add, 1 = nor, 2 = equal), pc_src (0 = pc+1, 1 = branch target, 2 = regA).
REQ-011 Port halted, output, 1: core stopped on halt.
REQ-012 Port fault, output, 1: memory timeout.
REQ-013 Port retired, output, CNT_W: count of completed instructions.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT and FAULT, one-hot or binary.
REQ-015 IDLE SHALL go to FETCH when start=1; HALT SHALL go to FETCH when start=1; start SHALL be ignored in all other states.
REQ-016 FETCH SHALL assert mem_req and ir_we, then advance to DECODE.
REQ-017 DECODE SHALL latch opcode into op_q; halt goes to HALT, noop goes to FETCH with pc_we=1 and pc_src=0, all other opcodes go to EXEC.
REQ-018 EXEC for add/nor SHALL drive alu_b_sel=1 and alu_op=0/1, then go to WB.
REQ-019 EXEC for lw/sw SHALL drive alu_b_sel=0 and alu_op=0, then go to MEM.
REQ-020 EXEC for beq SHALL drive alu_op=2, pc_we=1 and pc_src=alu_eq?1:0, then go to FETCH.
REQ-021 EXEC for jalr SHALL drive reg_we=1, wr_reg_sel=0, wr_data_sel=2, pc_we=1 and pc_src=2, then go to FETCH.
REQ-022 MEM SHALL assert mem_req, with mem_we=1 for sw; sw then goes to FETCH with pc_we=1, lw goes to WB.
REQ-023 WB SHALL assert reg_we=1 and pc_we=1 (pc_src=0), with wr_reg_sel=1 and wr_data_sel=1 for add/nor, or wr_reg_sel=0 and wr_data_sel=0 for lw, then go to FETCH.
REQ-024 Instruction latency SHALL be: noop 2, beq/jalr 3, add/nor/sw 4, lw 5 cycles; halt SHALL reach HALT 2 cycles after FETCH.
REQ-025 Outputs SHALL be Moore functions of state and op_q, except pc_src in EXEC beq and the DECODE branches; every control output not listed for a state SHALL be 0.
REQ-026 retired SHALL increment by 1 on the last cycle of each instruction and on entry to HALT, and SHALL saturate at all-ones.
REQ-027 halted SHALL be 1 exactly while in HALT.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, op_q=0, retired=0, fault=0 and all control outputs 0, including during any mid-instruction or mid-wait state.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro LC2K_CTRL_MEM_WAIT_EN defined: FETCH and MEM SHALL hold all outputs and stay in state until mem_ready=1, then advance.
REQ-031 Macro LC2K_CTRL_MEM_WAIT_EN defined: a wait counter SHALL clear on state entry; if mem_ready stays 0 for TO_CYC cycles the FSM SHALL enter FAULT, where fault=1, all controls are 0, and the state is sticky until reset.
REQ-032 Macro LC2K_CTRL_MEM_WAIT_EN undefined: mem_ready SHALL be ignored, FETCH and MEM SHALL last one cycle, and fault SHALL be tied to 0.

Verification
REQ-033 Reset, start, opcode=000, alu_eq=0 -> FETCH, DECODE, EXEC (alu_op=0, alu_b_sel=1), WB (reg_we=1, wr_data_sel=1), then retired=1 after 4 cycles.
REQ-034 beq with alu_eq=1 -> EXEC pc_src=1 and pc_we=1; with alu_eq=0 -> pc_src=0; each takes 3 cycles.
REQ-035 lw then halt -> 5+2 cycles, halted=1, retired=2; start pulse -> FETCH and halted=0.
REQ-036 WAIT_EN defined, mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with outputs stable; low for 15 cycles with TO_CYC=15 -> fault=1 and all controls 0.
REQ-037 CNT_W=2 with 5 noops -> retired saturates at 3.
REQ-038 rst_n pulsed low mid-EXEC -> outputs 0 asynchronously, IDLE entered, retired=0.

Source files
------------

// File: rtl/lc2k_ctrl_fsm.sv
// LC2K multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing plus a saturating retired counter.
// Optional macro LC2K_CTRL_MEM_WAIT_EN adds mem_ready handshaking with a timeout into a sticky FAULT state.
module lc2k_ctrl_fsm #(
   parameter int CNT_W  = 16,
   parameter int TO_CYC = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic             alu_eq,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ir_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_we,
   output logic             wr_reg_sel,
   output logic             alu_b_sel,
   output logic [1:0]       wr_data_sel,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NOR  = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_JALR = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_NOOP = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   state_t           r_state, w_next;
   logic [2:0]       r_op_q;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;
   logic             w_mem_go;
   logic             w_timeout;

`ifdef LC2K_CTRL_MEM_WAIT_EN
   logic [7:0] r_wait;

   assign w_mem_go  = mem_ready;
   assign w_timeout = !mem_ready && (r_wait == 8'(TO_CYC - 1));
   assign fault     = (r_state == S_FAULT);

   // Counts consecutive not-ready cycles; any state change restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                               r_wait <= '0;
      else if (w_next != r_state)                               r_wait <= '0;
      else if (!mem_ready && (r_state == S_FETCH || r_state == S_MEM)) r_wait <= r_wait + 8'd1;
   end
`else
   logic w_unused;

   assign w_mem_go  = 1'b1;
   assign w_timeout = 1'b0;
   assign fault     = 1'b0;
   assign w_unused  = mem_ready | (TO_CYC == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op_q    <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op_q <= opcode;
         if (w_retire && (r_retired != '1)) r_retired <= r_retired + 1'b1;
      end
   end

   assign retired = r_retired;

   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      reg_we      = 1'b0;
      wr_reg_sel  = 1'b0;
      alu_b_sel   = 1'b0;
      wr_data_sel = 2'd0;
      alu_op      = 2'd0;
      pc_src      = 2'd0;
      halted      = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_FETCH;
         S_FETCH: begin
            ir_we   = 1'b1;
            mem_req = 1'b1;
            if (w_timeout)     w_next = S_FAULT;
            else if (w_mem_go) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Decode steers on the live opcode; op_q is only valid from EXEC on.
            case (opcode)
               OP_HALT: begin
                  w_next   = S_HALT;
                  w_retire = 1'b1;
               end
               OP_NOOP: begin
                  pc_we    = 1'b1;
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (r_op_q)
               OP_ADD, OP_NOR: begin
                  alu_b_sel = 1'b1;
                  alu_op    = (r_op_q == OP_NOR) ? 2'd1 : 2'd0;
                  w_next    = S_WB;
               end
               OP_LW, OP_SW: w_next = S_MEM;
               OP_BEQ: begin
                  alu_op   = 2'd2;
                  pc_we    = 1'b1;
                  pc_src   = alu_eq ? 2'd1 : 2'd0;
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               OP_JALR: begin
                  reg_we      = 1'b1;
                  wr_data_sel = 2'd2;
                  pc_we       = 1'b1;
                  pc_src      = 2'd2;
                  w_next      = S_FETCH;
                  w_retire    = 1'b1;
               end
               default: w_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (r_op_q == OP_SW) begin
               mem_we = 1'b1;
               pc_we  = 1'b1;
            end
            if (w_timeout) w_next = S_FAULT;
            else if (w_mem_go) begin
               w_next   = (r_op_q == OP_SW) ? S_FETCH : S_WB;
               w_retire = (r_op_q == OP_SW);
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            if (r_op_q != OP_LW) begin
               wr_reg_sel  = 1'b1;
               wr_data_sel = 2'd1;
            end
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) w_next = S_FETCH;
         end
         S_FAULT: w_next = S_FAULT;
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lc2k_ctrl_fsm.sv
// Scoreboard bench for lc2k_ctrl_fsm: per-cycle stimulus and expected controls are queued together,
// then replayed and compared; a second instance with CNT_W=2 checks retired saturation.
module tb_lc2k_ctrl_fsm;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_NOR  = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_JALR = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_NOOP = 3'b111;

   // Bit positions inside the packed control vector.
   localparam int B_FLT = 0, B_HLT = 1, B_PSRC = 2, B_AOP = 4, B_WDS = 6, B_ABS = 8;
   localparam int B_WRS = 9, B_RWE = 10, B_MWE = 11, B_MRQ = 12, B_IRW = 13, B_PCW = 14;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic        alu_eq = 1'b0;
   logic        mem_ready = 1'b0;

   logic pc_we, ir_we, mem_req, mem_we, reg_we, wr_reg_sel, alu_b_sel, halted, fault;
   logic [1:0] wr_data_sel, alu_op, pc_src;
   logic [15:0] retired;
   logic pc_we2, ir_we2, mem_req2, mem_we2, reg_we2, wr_reg_sel2, alu_b_sel2, halted2, fault2;
   logic [1:0] wr_data_sel2, alu_op2, pc_src2;
   logic [1:0] retired2;
   logic [14:0] w_act, w_act2;

   assign w_act  = {pc_we, ir_we, mem_req, mem_we, reg_we, wr_reg_sel, alu_b_sel,
                    wr_data_sel, alu_op, pc_src, halted, fault};
   assign w_act2 = {pc_we2, ir_we2, mem_req2, mem_we2, reg_we2, wr_reg_sel2, alu_b_sel2,
                    wr_data_sel2, alu_op2, pc_src2, halted2, fault2};

   lc2k_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_eq(alu_eq),
      .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req),
      .mem_we(mem_we), .reg_we(reg_we), .wr_reg_sel(wr_reg_sel), .alu_b_sel(alu_b_sel),
      .wr_data_sel(wr_data_sel), .alu_op(alu_op), .pc_src(pc_src), .halted(halted),
      .fault(fault), .retired(retired)
   );

   lc2k_ctrl_fsm #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_eq(alu_eq),
      .mem_ready(mem_ready), .pc_we(pc_we2), .ir_we(ir_we2), .mem_req(mem_req2),
      .mem_we(mem_we2), .reg_we(reg_we2), .wr_reg_sel(wr_reg_sel2), .alu_b_sel(alu_b_sel2),
      .wr_data_sel(wr_data_sel2), .alu_op(alu_op2), .pc_src(pc_src2), .halted(halted2),
      .fault(fault2), .retired(retired2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] cv;
      int          ret;
      logic [2:0]  op;
      logic        eq;
      logic        st;
      logic        mr;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   m_ret = 0;
   logic m_halted = 1'b0;

   function automatic logic mr_val();
`ifdef LC2K_CTRL_MEM_WAIT_EN
      return 1'b1;
`else
      return 1'($urandom);
`endif
   endfunction

   task automatic push(input logic [14:0] c, input logic [2:0] op, input logic eq,
                       input logic st, input logic mr);
      ent_t e;
      e.cv = c; e.ret = m_ret; e.op = op; e.eq = eq; e.st = st; e.mr = mr;
      q.push_back(e);
   endtask

   task automatic push_start();
      logic [14:0] c;
      c = '0;
      c[B_HLT] = m_halted;
      push(c, 3'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      m_halted = 1'b0;
   endtask

   task automatic push_hold(input int n);
      logic [14:0] c;
      c = '0;
      c[B_HLT] = m_halted;
      repeat (n) push(c, 3'($urandom), 1'($urandom), 1'b0, 1'($urandom));
   endtask

   task automatic push_instr(input logic [2:0] op, input logic eq, input int mw);
      logic [14:0] c;
      c = '0; c[B_IRW] = 1'b1; c[B_MRQ] = 1'b1;
      push(c, 3'($urandom), 1'($urandom), 1'($urandom), mr_val());
      c = '0;
      if (op == OP_NOOP) c[B_PCW] = 1'b1;
      push(c, op, 1'($urandom), 1'($urandom), 1'($urandom));
      if (op == OP_NOOP || op == OP_HALT) begin
         m_ret++;
         if (op == OP_HALT) m_halted = 1'b1;
         return;
      end
      c = '0;
      case (op)
         OP_ADD:  c[B_ABS] = 1'b1;
         OP_NOR:  begin c[B_ABS] = 1'b1; c[B_AOP +: 2] = 2'd1; end
         OP_BEQ:  begin c[B_AOP +: 2] = 2'd2; c[B_PCW] = 1'b1; c[B_PSRC +: 2] = eq ? 2'd1 : 2'd0; end
         OP_JALR: begin c[B_RWE] = 1'b1; c[B_WDS +: 2] = 2'd2; c[B_PCW] = 1'b1; c[B_PSRC +: 2] = 2'd2; end
         default: c = '0;
      endcase
      push(c, 3'($urandom), eq, 1'($urandom), 1'($urandom));
      if (op == OP_BEQ || op == OP_JALR) begin m_ret++; return; end
      if (op == OP_LW || op == OP_SW) begin
         c = '0; c[B_MRQ] = 1'b1;
         if (op == OP_SW) begin c[B_MWE] = 1'b1; c[B_PCW] = 1'b1; end
`ifdef LC2K_CTRL_MEM_WAIT_EN
         repeat (mw) push(c, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         push(c, 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
`else
         if (mw < 0) c = '0;
         push(c, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`endif
         if (op == OP_SW) begin m_ret++; return; end
      end
      c = '0; c[B_RWE] = 1'b1; c[B_PCW] = 1'b1;
      if (op != OP_LW) begin c[B_WRS] = 1'b1; c[B_WDS +: 2] = 2'd1; end
      push(c, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      m_ret++;
   endtask

   // Replays queued cycles: drive on the falling edge, compare 1 time unit later.
   task automatic drain(input int n, input string name);
      ent_t e;
      int   er2;
      for (int i = 0; (n < 0 || i < n) && q.size() > 0; i++) begin
         e = q.pop_front();
         @(negedge clk);
         opcode = e.op; alu_eq = e.eq; start = e.st; mem_ready = e.mr;
         #1;
         er2 = (e.ret > 3) ? 3 : e.ret;
         checks++;
         if (w_act !== e.cv) begin
            failures++;
            $display("FAIL %s ctrl cyc%0d: got %h want %h", name, i, w_act, e.cv);
         end
         checks++;
         if (retired !== 16'(e.ret)) begin
            failures++;
            $display("FAIL %s retired cyc%0d: got %0d want %0d", name, i, retired, e.ret);
         end
         checks++;
         if (w_act2 !== e.cv) begin
            failures++;
            $display("FAIL %s ctrl2 cyc%0d: got %h want %h", name, i, w_act2, e.cv);
         end
         checks++;
         if (retired2 !== 2'(er2)) begin
            failures++;
            $display("FAIL %s retired2 cyc%0d: got %0d want %0d", name, i, retired2, er2);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         start = 1'b1; mem_ready = 1'b1;
         #1;
         checks++;
         if (w_act !== 15'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset: got ctrl %h ret %0d want 0 0", w_act, retired);
         end
      end
      start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_add();
      push_start();
      push_instr(OP_ADD, 1'b0, 0);
      drain(-1, "add");
   endtask

   task automatic test_alu();
      push_instr(OP_NOR, 1'b0, 0);
      push_instr(OP_ADD, 1'b1, 0);
      drain(-1, "alu");
   endtask

   task automatic test_branch();
      push_instr(OP_BEQ, 1'b1, 0);
      push_instr(OP_BEQ, 1'b0, 0);
      push_instr(OP_JALR, 1'b1, 0);
      drain(-1, "branch");
   endtask

   task automatic test_mem();
      push_instr(OP_SW, 1'b0, 0);
      push_instr(OP_LW, 1'b0, 3);
      push_instr(OP_SW, 1'b1, 2);
      drain(-1, "mem");
   endtask

   task automatic test_halt();
      push_instr(OP_LW, 1'b0, 0);
      push_instr(OP_HALT, 1'b0, 0);
      push_hold(3);
      push_start();
      push_instr(OP_ADD, 1'b0, 0);
      drain(-1, "halt");
   endtask

   task automatic test_saturate();
      repeat (5) push_instr(OP_NOOP, 1'b0, 0);
      drain(-1, "saturate");
   endtask

   task automatic test_back_to_back();
      logic [2:0] op;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 5));
         push_instr(op, 1'($urandom), int'($urandom_range(0, 4)));
      end
      push_instr(OP_HALT, 1'b0, 0);
      push_hold(2);
      drain(-1, "b2b");
   endtask

`ifdef LC2K_CTRL_MEM_WAIT_EN
   task automatic test_fault();
      logic [14:0] c;
      push_start();
      c = '0; c[B_IRW] = 1'b1; c[B_MRQ] = 1'b1;
      repeat (15) push(c, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      c = '0; c[B_FLT] = 1'b1;
      repeat (4) push(c, 3'($urandom), 1'($urandom), 1'b1, 1'b1);
      drain(-1, "fault");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (fault !== 1'b0 || w_act !== 15'd0) begin
         failures++;
         $display("FAIL fault_reset: got ctrl %h want 0", w_act);
      end
      m_ret = 0; m_halted = 1'b0; start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
`endif

   task automatic test_reset_mid_exec();
      logic [14:0] c;
      push_start();
      push_instr(OP_ADD, 1'b0, 0);
      drain(3, "midreset_pre");
      @(negedge clk);
      #1;
      c = '0; c[B_ABS] = 1'b1;
      checks++;
      if (w_act !== c) begin
         failures++;
         $display("FAIL midreset exec: got %h want %h", w_act, c);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (w_act !== 15'd0 || w_act2 !== 15'd0 || retired !== 16'd0 || retired2 !== 2'd0) begin
         failures++;
         $display("FAIL midreset async: got ctrl %h ret %0d want 0 0", w_act, retired);
      end
      q.delete();
      m_ret = 0; m_halted = 1'b0; start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_start();
      push_instr(OP_NOOP, 1'b0, 0);
      push_instr(OP_BEQ, 1'b1, 0);
      drain(-1, "midreset_post");
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu();
      test_branch();
      test_mem();
      test_halt();
      test_saturate();
      test_back_to_back();
`ifdef LC2K_CTRL_MEM_WAIT_EN
      test_fault();
`endif
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
